// File: rtl/tictactoe_game.sv
// rtl/tictactoe_game.sv - two-player tic-tac-toe referee with move arbitration and win/draw detection
// Moves are taken in PLAY_X/PLAY_O, judged for one cycle in CHECK, and the result held in DONE.
module tictactoe_game (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_accept,
  output logic       move_reject,
  output logic [8:0] x,
  output logic [8:0] o,
  output logic       turn_o,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [1:0] PLAY_X = 2'd0;
  localparam logic [1:0] PLAY_O = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  logic [1:0] state_q, state_d;
  logic [8:0] x_q, x_d;
  logic [8:0] o_q, o_d;
  logic [3:0] count_q, count_d;
  logic       mover_o_q, mover_o_d;
  logic [1:0] winner_q, winner_d;
  logic       accept_q, accept_d;
  logic       reject_q, reject_d;

  logic [8:0] cell_sel;
  logic       pos_in_range;
  logic       cell_taken;
  logic       move_legal;
  logic [8:0] check_board;
  logic       line_hit;

  function automatic logic has_line(input logic [8:0] b);
    has_line = (b[0] & b[1] & b[2]) |
               (b[3] & b[4] & b[5]) |
               (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) |
               (b[1] & b[4] & b[7]) |
               (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) |
               (b[2] & b[4] & b[6]);
  endfunction

  // One-hot decode of the requested cell; out-of-range positions decode to all zeros.
  always_comb begin
    cell_sel = 9'd0;
    for (int i = 0; i < 9; i++) begin
      cell_sel[i] = (move_pos == 4'(i));
    end
  end

  assign pos_in_range = (move_pos <= 4'd8);
  assign cell_taken   = |(cell_sel & (x_q | o_q));
  assign move_legal   = pos_in_range && !cell_taken;

  // Only the player who just moved can have completed a line.
  assign check_board = mover_o_q ? o_q : x_q;
  assign line_hit    = has_line(check_board);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    o_d       = o_q;
    count_d   = count_q;
    mover_o_d = mover_o_q;
    winner_d  = winner_q;
    accept_d  = 1'b0;
    reject_d  = 1'b0;

    case (state_q)
      PLAY_X, PLAY_O: begin
        if (move_valid) begin
          if (move_legal) begin
            if (state_q == PLAY_O) begin
              o_d = o_q | cell_sel;
            end else begin
              x_d = x_q | cell_sel;
            end
            count_d   = count_q + 4'd1;
            mover_o_d = (state_q == PLAY_O);
            accept_d  = 1'b1;
            state_d   = CHECK;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      CHECK: begin
        if (line_hit) begin
          state_d  = DONE;
          winner_d = mover_o_q ? WIN_O : WIN_X;
        end else if (count_q == 4'd9) begin
          state_d  = DONE;
          winner_d = WIN_DRAW;
        end else begin
          state_d = mover_o_q ? PLAY_X : PLAY_O;
        end
      end
      default: begin
      end
    endcase
  end

  // new_game behaves exactly like reset and pre-empts any move request on the same edge.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state_q   <= PLAY_X;
      x_q       <= 9'd0;
      o_q       <= 9'd0;
      count_q   <= 4'd0;
      mover_o_q <= 1'b0;
      winner_q  <= WIN_NONE;
      accept_q  <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      o_q       <= o_d;
      count_q   <= count_d;
      mover_o_q <= mover_o_d;
      winner_q  <= winner_d;
      accept_q  <= accept_d;
      reject_q  <= reject_d;
    end
  end

  assign move_ready  = (state_q == PLAY_X) || (state_q == PLAY_O);
  assign move_accept = accept_q;
  assign move_reject = reject_q;
  assign x           = x_q;
  assign o           = o_q;
  assign turn_o      = (state_q == PLAY_O) || ((state_q == CHECK) && mover_o_q);
  assign move_count  = count_q;
  assign game_over   = (state_q == DONE);
  assign winner      = (state_q == DONE) ? winner_q : WIN_NONE;

endmodule

// File: doc/tictactoe_game.md
TICTACTOE_GAME -- requirements
Module: tictactoe_game

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset: reset takes effect only on the rising edge of clk.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 new_game  input  1  synchronous clear of board and game state.
REQ-005 move_valid  input  1  current player requests a move.
REQ-006 move_pos  input  4  target cell 0..8, row-major; cell 0 is top-left; values 9..15 are illegal.
REQ-007 move_ready  output  1  block is able to accept a move this cycle.
REQ-008 move_accept  output  1  one-cycle pulse: the last request was taken.
REQ-009 move_reject  output  1  one-cycle pulse: the last request was refused.
REQ-010 x  output  9  X occupancy; bit i = cell i.
REQ-011 o  output  9  O occupancy; bit i = cell i.
REQ-012 turn_o  output  1  0 = X to move, 1 = O to move.
REQ-013 move_count  output  4  number of occupied cells, 0..9.
REQ-014 game_over  output  1  game finished.
REQ-015 winner  output  2  00 = none, 01 = X, 10 = O, 11 = draw.

Function
REQ-016 The FSM SHALL have four states: PLAY_X, PLAY_O, CHECK, DONE.
REQ-017 move_ready SHALL be 1 only in PLAY_X or PLAY_O.
REQ-018 A move is legal when move_pos <= 8 and (x|o)[move_pos] = 0.
REQ-019 Sampling move_valid=1 with move_ready=1 and a legal move at an edge SHALL, at that edge:
- set the mover's bit;
- increment move_count;
- register move_accept=1 for the following cycle;
- go to CHECK.
REQ-020 Sampling move_valid=1 with move_ready=1 and an illegal move SHALL:
- register move_reject=1 for the following cycle;
- leave the board, move_count and state unchanged, with the same player to move.
REQ-021 move_valid SHALL be ignored while move_ready=0; no accept and no reject.
REQ-022 In CHECK (one cycle), the mover's board SHALL be tested against 8 lines: {0,1,2} {3,4,5} {6,7,8} {0,3,6} {1,4,7} {2,5,8} {0,4,8} {2,4,6}.
REQ-023 CHECK transitions:
- line complete -> DONE, winner = mover;
- else move_count = 9 -> DONE, winner = 11;
- else -> the other player's PLAY state.
REQ-024 Throughput SHALL be at most one accepted move per 2 cycles; a new move is accepted no earlier than 2 edges after the previous accept.
REQ-025 turn_o SHALL be 1 exactly when the state is PLAY_O, or CHECK after an O move.
REQ-026 In DONE, game_over=1; the board, winner and move_count SHALL hold until reset or new_game.
REQ-027 winner SHALL be 00 in every state except DONE.
REQ-028 x & o SHALL always be 0; no cell is ever set for both players.
REQ-029 new_game=1 at an edge, in any state including CHECK, SHALL do the same as reset (REQ-031).
REQ-030 new_game SHALL win over a simultaneous move_valid: no accept and no reject pulse.

Reset
REQ-031 reset=1 at an edge SHALL set:
- state = PLAY_X; x = o = 0; move_count = 0; turn_o = 0;
- game_over = 0; winner = 00;
- move_accept = move_reject = 0.
It applies mid-game and overrides new_game and move_valid.
REQ-032 The first cycle after reset is released SHALL show move_ready=1.

Verification
REQ-033 Moves X0, O3, X1, O4, X2, each issued when move_ready=1 -> accept pulse after each move; after the final CHECK: x=000000111b, o=000011000b, winner=01, game_over=1, move_count=5.
REQ-034 X4, then O requests pos 4, then O requests pos 12 -> two move_reject pulses; o=0; turn_o stays 1; move_count=1.
REQ-035 Full board X0 O1 X2 O4 X3 O5 X7 O6 X8 -> x=110001101b, o=001110010b, no complete line, winner=11, move_count=9.
REQ-036 move_valid=1 held during CHECK and DONE -> no accept, no reject, board unchanged.
REQ-037 reset asserted in the cycle after an accept (state CHECK), and separately new_game asserted together with a legal move_valid -> next cycle: x=o=0, state PLAY_X, move_ready=1, no accept/reject pulse.
REQ-038 O wins on diagonal: X0 O2 X1 O4 X8 O6 -> winner=10, o=001010100b, game_over=1.
